key_encoder: RTL
================

# key_encoder

Parametrised keypad front end for the microwave controller: synchronises and priority-encodes an N-key active-high keypad, debounces the selected key, and emits one key-code event per press plus optional typematic repeats over a valid/ready handshake. It also generates the divided timebase tick and muxes it onto the timer-clock output when the keypad is disabled. It replaces the fixed 10-key encoder/debouncer/divider path feeding the time-load register.

## Interface
- `NKEYS`, 10: number of keypad lines, ≥2.
- `CODE_W`, 4: code width, ≥ ceil(log2(NKEYS)).
- `DEBOUNCE`, 16: clk cycles a key must be stable before acceptance, ≥1.
- `DIV`, 100: clk cycles per tick, ≥2.
- `REP_DELAY`, 50: ticks held before the first repeat; 0 disables repeat.
- `REP_RATE`, 10: ticks between subsequent repeats, ≥1.

- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `key`  in  NKEYS  raw asynchronous key lines, active-high.
- `enablen`  in  1  active-low keypad enable; high means the keypad is ignored.
- `code`  out  CODE_W  encoded key index of the current event.
- `valid`  out  1  event pending.
- `ready`  in  1  consumer accepts the event when `valid && ready`.
- `loadn`  out  1  low while a debounced key is held.
- `tick`  out  1  one-cycle pulse every DIV cycles.
- `pgt_1Hz`  out  1  `tick` when `enablen`=1; otherwise a one-cycle pulse per emitted event (press or repeat).
- `overflow`  out  1  sticky; an event was dropped.

## Operation
- Two-flop synchroniser on `key`. Priority encode: the lowest set index wins; `any` = OR of the synchronised lines. `enablen`=1 forces `any`=0.
- FSM states:
  - IDLE: wait for `any`.
  - DEB: count `DEBOUNCE` cycles while the encoded index stays equal to the latched index. A change of index restarts DEB with the new index. Loss of `any` returns to IDLE.
  - HELD: emit the press event on entry. Then count REP_DELAY ticks → REP.
  - REP: emit an event every REP_RATE ticks.
  - Exit from HELD/REP: `any` deasserts, or the index changes → REL.
  - REL: count `DEBOUNCE` cycles with `any`=0, then → IDLE. A reassertion restarts the REL count.
- An index change while in HELD or REP goes through REL. No new press is accepted until release completes.
- `loadn`=0 in HELD and REP, 1 otherwise.
- Output register is one entry deep. An event is loaded when `!valid` or when it is accepted in the same cycle. Otherwise the event is dropped and `overflow` is set. `overflow` clears only on reset.
- `enablen` rising while in HELD or REP → immediate transition to REL; `valid` and its pending event are unaffected.
- Divider is a free-running mod-DIV counter, independent of the FSM and of `enablen`.

## Timing
- Reset values:
  - `code`=0, `valid`=0, `loadn`=1, `tick`=0, `pgt_1Hz`=0, `overflow`=0.
  - FSM=IDLE, all counters 0.
- Press latency: a stable key line produces `valid`=1 exactly 2 (sync) + 1 (IDLE→DEB) + DEBOUNCE + 1 (register) cycles after its first rising clk edge.
- `valid` stays high with a stable `code` until the handshake completes. It deasserts the cycle after `valid && ready` unless a new event loads in that same cycle.
- `tick` is high in the cycle where the divider wraps from DIV-1 to 0. The first tick comes DIV cycles after reset release.
- Repeat:
  - The first repeat fires on the REP_DELAY-th tick counted from HELD entry.
  - Later repeats fire every REP_RATE ticks.
  - A partial tick period at HELD entry counts as a whole tick.
- `pgt_1Hz` is registered and lags the event-load cycle by 0 cycles; it is asserted in the same cycle `valid` rises.
- Reset asserted mid-operation returns all state to reset values asynchronously.

## Structure
- Package `key_encoder_pkg`: FSM state enum (IDLE, DEB, HELD, REP, REL) and a function computing the required CODE_W from NKEYS. Parameter legality is checked in elaboration.
- One sub-module: `tick_div`, a parametrised mod-DIV counter that outputs `tick`. It replaces the fixed divide-by-100.

## Test plan
- Reset mid-DEB with key 3 held → all outputs at reset values. After release of `resetn`, key 3 still held → `valid`=1 with `code`=3 at cycle 2+1+DEBOUNCE+1.
- Bounce on key 5 (toggles every 4 cycles for 40 cycles, DEBOUNCE=16), then stable → exactly one event, `code`=5, `loadn` low only after the stable window.
- Keys 2 and 7 pressed together → `code`=2. Release key 2 with 7 still held → REL entered, no event for 7 until all keys are released and pressed again.
- DIV=4, REP_DELAY=3, REP_RATE=2, key 1 held for 40 cycles with `ready`=1 → a press event plus repeats spaced 8 cycles apart, the first repeat 3 ticks after HELD entry.
- `ready`=0, two presses of key 4 → the first event is held stable, the second is dropped, `overflow`=1 and it stays set.
- `enablen`=1 with keys pressed → no events, `loadn`=1, `pgt_1Hz` equal to `tick`, one pulse per DIV cycles.

Source files
------------

// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg
//   Shared types and helpers for the keypad front end.
//   state_e     : debounce/repeat FSM states.
//   code_w_min  : smallest code width able to index NKEYS key lines.
package key_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB,
    HELD,
    REP,
    REL
  } state_e;

  function automatic int unsigned code_w_min(input int unsigned nkeys);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < nkeys) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/key_encoder_tick_div.sv
// tick_div
//   Free-running mod-DIV counter producing the keypad timebase.
//   clk    in  : system clock
//   resetn in  : asynchronous active-low reset
//   tick   out : registered one-cycle pulse, high in the cycle after the
//                counter wraps from DIV-1 to 0 (first pulse DIV cycles
//                after reset release)
module tick_div #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;
  logic          wrap;

  assign wrap  = (cnt_q == LAST);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/key_encoder.sv
// key_encoder
//   Keypad front end: synchronises and priority-encodes NKEYS active-high
//   key lines, debounces the selected key, emits one event per press plus
//   optional typematic repeats over valid/ready, and provides the divided
//   timebase tick.
//   clk      in  : system clock
//   resetn   in  : asynchronous active-low reset
//   key      in  : raw asynchronous key lines (lowest index has priority)
//   enablen  in  : active-low keypad enable
//   code     out : key index of the pending event
//   valid    out : event pending
//   ready    in  : consumer accepts when valid && ready
//   loadn    out : low while a debounced key is held
//   tick     out : one-cycle pulse every DIV cycles
//   pgt_1Hz  out : tick when disabled, else one pulse per loaded event
//   overflow out : sticky, an event was dropped
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int unsigned NKEYS     = 10,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned DEBOUNCE  = 16,
  parameter int unsigned DIV       = 100,
  parameter int unsigned REP_DELAY = 50,
  parameter int unsigned REP_RATE  = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NKEYS-1:0]  key,
  input  logic              enablen,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              loadn,
  output logic              tick,
  output logic              pgt_1Hz,
  output logic              overflow
);

  if (NKEYS < 2) begin : g_bad_nkeys
    $error("key_encoder: NKEYS must be at least 2");
  end
  if (CODE_W < code_w_min(NKEYS)) begin : g_bad_code_w
    $error("key_encoder: CODE_W too narrow for NKEYS");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("key_encoder: DEBOUNCE must be at least 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("key_encoder: DIV must be at least 2");
  end
  if (REP_RATE < 1) begin : g_bad_rep_rate
    $error("key_encoder: REP_RATE must be at least 1");
  end

  localparam int unsigned DCW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DCW-1:0] D_LAST  = DCW'(DEBOUNCE - 1);
  localparam logic [RCW-1:0] RD_LAST = (REP_DELAY == 0) ? '0 : RCW'(REP_DELAY - 1);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REP_RATE - 1);

  logic [NKEYS-1:0]  sync1_q, sync2_q;
  logic [CODE_W-1:0] enc_idx;
  logic              any_key;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic              emit_q, emit_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              pgt_q, pgt_d;
  logic              tick_w;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick_w)
  );

  // Stage 0: two-flop synchroniser on the raw key lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    enc_idx = '0;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (sync2_q[i]) enc_idx = CODE_W'(i);
    end
  end

  assign any_key = ~enablen & (|sync2_q);

  // Stage 1: debounce / hold / repeat / release FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    emit_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_key) begin
          state_d = DEB;
          idx_d   = enc_idx;
          dcnt_d  = '0;
        end
      end
      DEB: begin
        if (!any_key) begin
          state_d = IDLE;
        end else if (enc_idx != idx_q) begin
          idx_d  = enc_idx;
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = HELD;
          emit_d  = 1'b1;
          rcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        // A different key while held must go through a full release.
        if (!any_key || (enc_idx != idx_q)) begin
          state_d = REL;
          dcnt_d  = '0;
        end else if ((REP_DELAY != 0) && tick_w) begin
          if (rcnt_q == RD_LAST) begin
            state_d = REP;
            rcnt_d  = '0;
            emit_d  = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      REP: begin
        if (!any_key || (enc_idx != idx_q)) begin
          state_d = REL;
          dcnt_d  = '0;
        end else if (tick_w) begin
          if (rcnt_q == RR_LAST) begin
            rcnt_d = '0;
            emit_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      REL: begin
        if (any_key) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      emit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      emit_q  <= emit_d;
    end
  end

  // Stage 2: one-deep output register; a blocked event is dropped
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    pgt_d   = 1'b0;
    if (emit_q) begin
      if (!valid_q || ready) begin
        code_d  = idx_q;
        valid_d = 1'b1;
        pgt_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pgt_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      pgt_q   <= pgt_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign loadn    = ~((state_q == HELD) || (state_q == REP));
  assign tick     = tick_w;
  assign pgt_1Hz  = enablen ? tick_w : pgt_q;

endmodule
